data_memory_ctrl: RTL and testbench



---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_lane_ext.sv | 34 +++
 rtl/data_memory_ctrl.sv | 132 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data memory controller: DMCtrl size codes,
// FSM state encoding and the access-size decoder.
package dm_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Access size in bytes; 0 marks an illegal code.
    function automatic logic [2:0] dm_size(input logic [2:0] ctrl);
        case (ctrl)
            DM_B, DM_BU: dm_size = 3'd1;
            DM_H, DM_HU: dm_size = 3'd2;
            DM_W:        dm_size = 3'd4;
            default:     dm_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Byte-enable generation for stores and sign/zero extension for loads.
// Pure combinational; lane 0 is the byte at the access address.
module dm_lane_ext
    import dm_pkg::*;
(
    input  logic [2:0]  ctrl_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] load_o
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        be_o = 4'b0000;
        case (dm_size(ctrl_i))
            3'd1:    be_o = 4'b0001;
            3'd2:    be_o = 4'b0011;
            3'd4:    be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    always_comb begin
        load_o = raw_i;
        case (ctrl_i)
            DM_B:    load_o = {{24{raw_i[7]}}, raw_i[7:0]};
            DM_BU:   load_o = {24'd0, raw_i[7:0]};
            DM_H:    load_o = {{16{raw_i[15]}}, raw_i[15:0]};
            DM_HU:   load_o = {16'd0, raw_i[15:0]};
            default: load_o = raw_i;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data RAM with a valid/ready request/response
// handshake, configurable wait states, byte-enabled stores and fault checks.
module data_memory_ctrl
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned LATENCY     = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    // Counter reload so that the array access lands on edge accept+LATENCY.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dm_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept, commit;

    logic [7:0]  mem [0:DEPTH_BYTES-1];
    logic [AW-1:0] idx [4];
    logic [31:0] raw;
    logic [3:0]  be;
    logic [31:0] load_data;
    logic [2:0]  size_b;
    logic [32:0] last_byte;
    logic        acc_err;

    assign size_b    = dm_size(ctrl_q);
    // 33-bit sum so an access near 0xFFFFFFFF cannot wrap into range.
    assign last_byte = {1'b0, addr_q} + {30'd0, size_b} - 33'd1;
    assign acc_err   = (size_b == 3'd0)
                    || (we_q && ctrl_q[2])
                    || (size_b == 3'd2 && addr_q[0])
                    || (size_b == 3'd4 && addr_q[1:0] != 2'b00)
                    || (last_byte >= 33'(DEPTH_BYTES));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k]       = addr_q[AW-1:0] + AW'(k);
            raw[8*k +: 8] = mem[idx[k]];
        end
    end

    dm_lane_ext u_lane_ext (
        .ctrl_i (ctrl_q),
        .raw_i  (raw),
        .be_o   (be),
        .load_o (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: if (req_valid) begin
                accept  = 1'b1;
                cnt_d   = CNT_INIT;
                state_d = ST_BUSY;
            end
            ST_BUSY: if (cnt_q == 4'd0) begin
                commit  = 1'b1;
                state_d = ST_RESP;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            ctrl_q  <= DM_B;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                ctrl_q  <= req_ctrl;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                err_q   <= acc_err;
                rdata_q <= (acc_err || we_q) ? 32'd0 : load_data;
            end
        end
    end

    // NOTE: the array has no reset; a reset landing on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (commit && !rst && we_q && !acc_err) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx[k]] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: instance 0 runs with LATENCY=1, instance 1 with LATENCY=4.
module tb_data_memory_ctrl;
    import dm_pkg::*;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst        [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_ctrl   [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_ctrl(req_ctrl[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_ctrl(req_ctrl[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction: request, bounded wait for the response, checks, release.
    task automatic txn(input int d, input logic we, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int lat;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_ctrl[d]  = ctrl;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        check({tag, " rdata"}, rsp_rdata[d], exp_rd);
        check({tag, " err"}, 32'(rsp_err[d]), 32'(exp_err));
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_ctrl[d] = 3'b000;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        for (int d = 0; d < 2; d++) begin
            check("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset req_ready", 32'(req_ready[d]), 32'd1);
            check("reset rsp_rdata", rsp_rdata[d], 32'd0);
            check("reset rsp_err",   32'(rsp_err[d]), 32'd0);
        end

        // Basic store/load round trip
        txn(0, 1, DM_W, 32'h10, 32'hDEADBEEF, 32'd0, 0, "t1 sw");
        txn(0, 0, DM_W, 32'h10, 32'd0, 32'hDEADBEEF, 0, "t1 lw");

        // Byte enables preserve unaddressed bytes
        txn(0, 1, DM_W, 32'h20, 32'h11223344, 32'd0, 0, "t2 sw");
        txn(0, 1, DM_B, 32'h21, 32'hFFFFFFAA, 32'd0, 0, "t2 sb");
        txn(0, 1, DM_H, 32'h22, 32'hFFFFBBCC, 32'd0, 0, "t2 sh");
        txn(0, 0, DM_W, 32'h20, 32'd0, 32'hBBCCAA44, 0, "t2 lw");

        // Sign / zero extension
        txn(0, 1, DM_H,  32'h30, 32'h0000FF80, 32'd0, 0, "t3 sh");
        txn(0, 0, DM_B,  32'h30, 32'd0, 32'hFFFFFF80, 0, "t3 lb");
        txn(0, 0, DM_BU, 32'h30, 32'd0, 32'h00000080, 0, "t3 lbu");
        txn(0, 0, DM_H,  32'h30, 32'd0, 32'hFFFFFF80, 0, "t3 lh");
        txn(0, 0, DM_HU, 32'h30, 32'd0, 32'h0000FF80, 0, "t3 lhu");
        txn(0, 0, DM_BU, 32'h31, 32'd0, 32'h000000FF, 0, "t3 lbu odd");

        // Faults and range boundary
        txn(0, 1, DM_W, DEPTH - 4, 32'h01020304, 32'd0, 0, "t4 sw top");
        txn(0, 0, DM_H,  32'h31, 32'd0, 32'd0, 1, "t4 lh misaligned");
        txn(0, 0, DM_W,  32'h32, 32'd0, 32'd0, 1, "t4 lw misaligned");
        txn(0, 1, DM_W,  DEPTH - 2, 32'hFFFFFFFF, 32'd0, 1, "t4 sw out of range");
        txn(0, 0, 3'b011, 32'h10, 32'd0, 32'd0, 1, "t4 ctrl 011");
        txn(0, 0, 3'b110, 32'h10, 32'd0, 32'd0, 1, "t4 ctrl 110");
        txn(0, 1, DM_BU, 32'h20, 32'h00000077, 32'd0, 1, "t4 sb with 100");
        txn(0, 1, DM_W,  32'hFFFFFFFC, 32'h99999999, 32'd0, 1, "t4 sw wrap addr");
        txn(0, 0, DM_W,  DEPTH - 4, 32'd0, 32'h01020304, 0, "t4 lw top unchanged");
        txn(0, 0, DM_W,  32'h20, 32'd0, 32'hBBCCAA44, 0, "t4 lw 0x20 unchanged");
        txn(0, 0, DM_HU, DEPTH - 2, 32'd0, 32'h00000102, 0, "t4 lhu last half");
        txn(0, 0, DM_BU, DEPTH - 1, 32'd0, 32'h00000001, 0, "t4 lbu last byte");
        txn(0, 0, DM_BU, DEPTH, 32'd0, 32'd0, 1, "t4 lbu past end");

        // LATENCY=4 with back-pressure; a second request while busy is ignored
        txn(1, 1, DM_W, 32'h10, 32'hCAFEF00D, 32'd0, 0, "t5 sw");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_ctrl[1] = DM_W;
        req_addr[1] = 32'h10; req_wdata[1] = 32'd0;
        @(posedge clk);
        #1 req_we[1] = 1'b1;
        req_wdata[1] = 32'h55555555;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 check("t5 busy rsp_valid", 32'(rsp_valid[1]), 32'd0);
            check("t5 busy req_ready", 32'(req_ready[1]), 32'd0);
        end
        @(posedge clk);
        #1 check("t5 rsp_valid at T+4", 32'(rsp_valid[1]), 32'd1);
        check("t5 rdata", rsp_rdata[1], 32'hCAFEF00D);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 check("t5 held rsp_valid", 32'(rsp_valid[1]), 32'd1);
            check("t5 held rdata", rsp_rdata[1], 32'hCAFEF00D);
            check("t5 held req_ready", 32'(req_ready[1]), 32'd0);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1 rsp_ready[1] = 1'b0;
        check("t5 released rsp_valid", 32'(rsp_valid[1]), 32'd0);
        txn(1, 0, DM_W, 32'h10, 32'd0, 32'hCAFEF00D, 0, "t5 lw after ignored sw");

        // Reset while BUSY discards the pending store
        txn(1, 1, DM_W, 32'h40, 32'd0, 32'd0, 0, "t6 clear");
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_ctrl[1] = DM_W;
        req_addr[1] = 32'h40; req_wdata[1] = 32'h12345678;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        #1 check("t6 rsp_valid after rst", 32'(rsp_valid[1]), 32'd0);
        check("t6 req_ready after rst", 32'(req_ready[1]), 32'd1);
        @(negedge clk);
        rst[1] = 1'b0;
        repeat (4) @(posedge clk);
        check("t6 no spurious rsp", 32'(rsp_valid[1]), 32'd0);
        txn(1, 0, DM_W, 32'h40, 32'd0, 32'd0, 0, "t6 lw discarded");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
